// File: rtl/simmem_pkg.sv
// rtl/simmem_pkg.sv - shared simmem types for the write response path
package simmem_pkg;

  localparam int unsigned IdWidth      = 8;
  localparam int unsigned AddrWidth    = 32;
  localparam int unsigned DataWidth    = 32;
  localparam int unsigned AxLenWidth   = 8;
  localparam int unsigned AxSizeWidth  = 3;
  localparam int unsigned XRespWidth   = 1;
  // One extra bit so a 256-beat burst (len=255) is representable without wrap.
  localparam int unsigned BeatCntWidth = AxLenWidth + 1;

  typedef struct packed {
    logic [IdWidth-1:0]     id;
    logic [AddrWidth-1:0]   addr;
    logic [AxLenWidth-1:0]  burst_length;
    logic [AxSizeWidth-1:0] burst_size;
  } write_addr_req_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic                 last;
  } write_data_req_t;

  typedef enum logic [XRespWidth-1:0] {
    WRESP_OKAY   = 1'b0,
    WRESP_SLVERR = 1'b1
  } wresp_e;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    wresp_e             rsp;
  } write_resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wresp_state_e;

  // Beats a burst must carry, computed at counter width so len=255 gives 256.
  function automatic logic [BeatCntWidth-1:0] expected_beats(input logic [AxLenWidth-1:0] len);
    return {1'b0, len} + {{(BeatCntWidth-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/simmem_req_fifo.sv
// rtl/simmem_req_fifo.sv - valid/ready request FIFO with occupancy count
module simmem_req_fifo
  import simmem_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  write_addr_req_t         in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output write_addr_req_t         out_data_o,
  output logic [$clog2(Depth):0]  count_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam logic [PtrWidth:0] FullCount = (PtrWidth+1)'(Depth);

  write_addr_req_t        mem [Depth];
  logic [PtrWidth-1:0]    wr_ptr_q;
  logic [PtrWidth-1:0]    rd_ptr_q;
  logic [PtrWidth:0]      count_q;
  logic                   push;
  logic                   pop;

  // Ready depends only on stored occupancy: a same-cycle pop never frees a slot early.
  assign in_ready_o  = (count_q != FullCount);
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = mem[rd_ptr_q];
  assign count_o     = count_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Storage array; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data_i;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/simmem_write_responder.sv
// rtl/simmem_write_responder.sv - terminates AW/W traffic and returns one B per burst
module simmem_write_responder
  import simmem_pkg::*;
#(
  parameter int unsigned AwFifoDepth = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          aw_in_valid_i,
  output logic                          aw_in_ready_o,
  input  write_addr_req_t               aw_in_data_i,
  input  logic                          w_in_valid_i,
  output logic                          w_in_ready_o,
  input  write_data_req_t               w_in_data_i,
  output logic                          b_out_valid_o,
  input  logic                          b_out_ready_i,
  output write_resp_t                   b_out_data_o,
  output logic [$clog2(AwFifoDepth):0]  outstanding_o
);

  localparam int unsigned CntWidth = $clog2(AwFifoDepth) + 1;
  localparam logic [CntWidth-1:0] OneEntry = CntWidth'(1);

  wresp_state_e               state_q, state_d;
  logic [BeatCntWidth-1:0]    beat_cnt_q, beat_cnt_d, beat_cnt_inc;
  logic                       err_q, err_d;
  write_addr_req_t            head;
  logic                       head_valid;
  logic                       aw_push;
  logic                       w_hs;
  logic                       b_hs;

  simmem_req_fifo #(
    .Depth (AwFifoDepth)
  ) u_aw_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (aw_in_valid_i),
    .in_ready_o  (aw_in_ready_o),
    .in_data_i   (aw_in_data_i),
    .out_valid_o (head_valid),
    .out_ready_i (b_hs),
    .out_data_o  (head),
    .count_o     (outstanding_o)
  );

  assign aw_push       = aw_in_valid_i & aw_in_ready_o;
  assign w_in_ready_o  = (state_q == WR_DATA);
  assign b_out_valid_o = (state_q == WR_RESP);
  assign w_hs          = w_in_valid_i & w_in_ready_o;
  assign b_hs          = b_out_valid_o & b_out_ready_i;
  // Saturate so runaway bursts can never wrap back onto the expected count.
  assign beat_cnt_inc  = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + 1'b1;

  // Response is driven from registered state only, so it holds while stalled.
  always_comb begin
    b_out_data_o = '0;
    if (state_q == WR_RESP) begin
      b_out_data_o.id  = head.id;
      b_out_data_o.rsp = err_q ? WRESP_SLVERR : WRESP_OKAY;
    end
  end

  // Next-state logic: count beats, accumulate errors, retire the head on B.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    case (state_q)
      WR_IDLE: begin
        if (head_valid) state_d = WR_DATA;
      end
      WR_DATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_inc;
          err_d      = err_q | (w_in_data_i.id != head.id);
          if (w_in_data_i.last) begin
            state_d = WR_RESP;
            if (beat_cnt_inc != expected_beats(head.burst_length)) err_d = 1'b1;
          end
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          beat_cnt_d = '0;
          err_d      = 1'b0;
          // Another burst is ready if an entry survives the pop or one arrives now.
          state_d    = ((outstanding_o > OneEntry) || aw_push) ? WR_DATA : WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // State, beat counter and error flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= WR_IDLE;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_simmem_write_responder.sv
// tb/tb_simmem_write_responder.sv - scoreboard bench for simmem_write_responder
module tb_simmem_write_responder;
  import simmem_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            aw_valid = 1'b0;
  logic            aw_ready;
  write_addr_req_t aw_data = '0;
  logic            w_valid = 1'b0;
  logic            w_ready;
  write_data_req_t w_data = '0;
  logic            b_valid;
  logic            b_ready = 1'b1;
  write_resp_t     b_data;
  logic [2:0]      outstanding;

  int checks = 0;
  int errors = 0;
  write_resp_t exp_q[$];

  simmem_write_responder #(
    .AwFifoDepth (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .aw_in_valid_i (aw_valid),
    .aw_in_ready_o (aw_ready),
    .aw_in_data_i  (aw_data),
    .w_in_valid_i  (w_valid),
    .w_in_ready_o  (w_ready),
    .w_in_data_i   (w_data),
    .b_out_valid_o (b_valid),
    .b_out_ready_i (b_ready),
    .b_out_data_o  (b_data),
    .outstanding_o (outstanding)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic write_resp_t mk_resp(input logic [7:0] id, input wresp_e rsp);
    write_resp_t r;
    r.id  = id;
    r.rsp = rsp;
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic aw_send(input logic [7:0] id, input logic [7:0] len);
    int n = 0;
    aw_valid = 1'b1;
    aw_data  = '0;
    aw_data.id = id;
    aw_data.addr = $urandom;
    aw_data.burst_length = len;
    aw_data.burst_size = 3'd2;
    while (!aw_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2000) check("aw_timeout", {31'b0, aw_ready}, 32'd1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  task automatic w_beat(input logic [7:0] id, input logic last);
    int n = 0;
    w_valid = 1'b1;
    w_data.id   = id;
    w_data.data = $urandom;
    w_data.last = last;
    while (!w_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2000) check("w_timeout", {31'b0, w_ready}, 32'd1);
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic burst(input logic [7:0] id, input logic [7:0] len, input logic [7:0] wid,
                       input int nbeats, input wresp_e rsp);
    exp_q.push_back(mk_resp(id, rsp));
    aw_send(id, len);
    for (int i = 1; i <= nbeats; i++) w_beat(wid, (i == nbeats));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // B monitor: pops the scoreboard on each handshake and checks hold-while-stalled.
  logic        prev_stall = 1'b0;
  write_resp_t prev_b = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("b_hold_valid", {31'b0, b_valid}, 32'd1);
        check("b_hold_data", {23'b0, b_data}, {23'b0, prev_b});
      end
      if (b_valid && b_ready) begin
        if (exp_q.size() == 0) check("b_unexpected", {31'b0, b_valid}, 32'd0);
        else check("b_resp", {23'b0, b_data}, {23'b0, exp_q.pop_front()});
      end
      prev_stall <= b_valid && !b_ready;
      prev_b     <= b_data;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_aw_ready", {31'b0, aw_ready}, 32'd1);
    check("rst_w_ready", {31'b0, w_ready}, 32'd0);
    check("rst_b_valid", {31'b0, b_valid}, 32'd0);
    check("rst_b_data", {23'b0, b_data}, 32'd0);
    check("rst_outstanding", {29'b0, outstanding}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single burst with latency checks.
    exp_q.push_back(mk_resp(8'h3, WRESP_OKAY));
    aw_send(8'h3, 8'd3);
    check("w_ready_after_aw", {31'b0, w_ready}, 32'd0);
    for (int i = 1; i <= 4; i++) w_beat(8'h3, (i == 4));
    check("b_latency", {31'b0, b_valid}, 32'd1);
    drain("drain_single");

    // Short burst then a clean burst.
    burst(8'h5, 8'd3, 8'h5, 2, WRESP_SLVERR);
    burst(8'h6, 8'd1, 8'h6, 2, WRESP_OKAY);
    drain("drain_short");

    // ID mismatch.
    burst(8'h1, 8'd0, 8'h2, 1, WRESP_SLVERR);
    drain("drain_idmis");

    // Excess beats: len=1 but last only on beat 3.
    burst(8'h9, 8'd1, 8'h9, 3, WRESP_SLVERR);
    drain("drain_excess");

    // Backpressure and ordering.
    b_ready = 1'b0;
    for (int k = 1; k <= 4; k++) aw_send(8'(k), 8'd0);
    check("bp_aw_ready_full", {31'b0, aw_ready}, 32'd0);
    check("bp_outstanding", {29'b0, outstanding}, 32'd4);
    for (int k = 1; k <= 5; k++) exp_q.push_back(mk_resp(8'(k), WRESP_OKAY));
    w_beat(8'h1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("bp_outstanding_stall", {29'b0, outstanding}, 32'd4);
    fork
      aw_send(8'h5, 8'd0);
      for (int k = 2; k <= 5; k++) w_beat(8'(k), 1'b1);
      begin
        repeat (5) @(posedge clk);
        #1 b_ready = 1'b1;
      end
    join
    drain("drain_bp");

    // Maximum length burst.
    burst(8'h7, 8'd255, 8'h7, 256, WRESP_OKAY);
    drain("drain_max");

    // Reset mid-burst.
    aw_send(8'hA, 8'd3);
    w_beat(8'hA, 1'b0);
    w_beat(8'hA, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_aw_ready", {31'b0, aw_ready}, 32'd1);
    check("mid_rst_w_ready", {31'b0, w_ready}, 32'd0);
    check("mid_rst_b_valid", {31'b0, b_valid}, 32'd0);
    check("mid_rst_b_data", {23'b0, b_data}, 32'd0);
    check("mid_rst_outstanding", {29'b0, outstanding}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_b", {31'b0, b_valid}, 32'd0);
    burst(8'hB, 8'd1, 8'hB, 2, WRESP_OKAY);
    drain("drain_post_rst");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
